mem_lsu: RTL
============

MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 Parameter XLEN, default 32, data width; legal values 32 or 64.
REQ-002 Parameter ADDR_W, default 32, byte address width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 ex_valid_i  in  1  EX stage presents an instruction.
REQ-006 ex_ready_o  out  1  block accepts an instruction this cycle.
REQ-007 inst_i  in  32  instruction word; funct3 is bits 14:12.
REQ-008 mem_rena_i / mem_wena_i  in  1 each  load / store request.
REQ-009 mem_addr_i  in  ADDR_W  byte address; mem_wdata_i  in  XLEN  store data.
REQ-010 reg_wena_i  in  1, reg_waddr_i  in  5, reg_wdata_i  in  XLEN  register write-back from EX.
REQ-011 bus_req_o  out  1, bus_we_o  out  1, bus_addr_o  out  ADDR_W (word-aligned to XLEN/8), bus_wdata_o  out  XLEN (lane-shifted), bus_be_o  out  XLEN/8.
REQ-012 bus_gnt_i  in  1  request accepted; bus_rvalid_i  in  1  response (read data or write ack); bus_rdata_i  in  XLEN.
REQ-013 wb_valid_o  out  1, wb_inst_o  out  32, wb_reg_wena_o  out  1, wb_reg_waddr_o  out  5, wb_reg_wdata_o  out  XLEN  registered write-back outputs.
REQ-014 busy_o  out  1  high when state is not IDLE (pipeline stall).

Function
REQ-015 FSM states: IDLE, REQ, WAIT; ex_ready_o SHALL be (state==IDLE) and not rst.
REQ-016 IDLE, accept with neither mem_rena_i nor mem_wena_i: the next edge SHALL drive wb_* from the inputs with wb_valid_o=1; state stays IDLE (latency 1).
REQ-017 IDLE, accept with load or store: inputs SHALL be latched, state goes to REQ; wb_valid_o=0 next cycle.
REQ-018 REQ: bus_req_o=1 with stable addr/we/be/wdata until the cycle bus_gnt_i=1, then state goes to WAIT.
REQ-019 WAIT: bus_rvalid_i=1 SHALL complete the access: wb_valid_o pulses for one cycle, state returns to IDLE; minimum memory-op latency is 3 cycles from accept.
REQ-020 bus_rvalid_i SHALL be ignored in IDLE and REQ.
REQ-021 mem_rena_i and mem_wena_i both high: store takes priority, load ignored.
REQ-022 Load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; for XLEN=64 also 011 LD, 110 LWU; the lane is selected by addr low bits and sign- or zero-extended to XLEN into wb_reg_wdata_o.
REQ-023 Store funct3: 000 SB, 001 SH, 010 SW, 011 SD (XLEN=64 only); bus_be_o marks the addressed bytes; bus_wdata_o carries data replicated to the addressed lane.
REQ-024 Unlisted funct3 SHALL be treated as full-width access.
REQ-025 Store completion: wb_reg_wena_o SHALL equal the latched reg_wena_i and wb_reg_wdata_o the latched reg_wdata_i.
REQ-026 Load completion: wb_reg_wena_o=1 and wb_reg_waddr_o = the latched reg_waddr_i.

Reset
REQ-027 rst high at an edge: state becomes IDLE; all wb_* outputs and bus_req_o are 0 after that edge; ex_ready_o and busy_o are 0 while rst is high.
REQ-028 Reset mid-access (REQ or WAIT) SHALL abandon the access; a later bus_rvalid_i SHALL be ignored per REQ-020.

Configuration
REQ-029 Macro MISALIGN_TRAP_EN defined: a misaligned LH/LHU/SH (addr[0]), LW/LWU/SW (addr[1:0]) or LD/SD (addr[2:0]) SHALL issue no bus request; the next cycle SHALL give wb_valid_o=1, wb_reg_wena_o=0 and output misalign_o=1 for one cycle.
REQ-030 Macro MISALIGN_TRAP_EN undefined: misalign_o is absent, and the offending low address bits are forced to zero before the access.

Verification
REQ-031 XLEN=32, LW addr 0x100, gnt same cycle as req, rvalid next cycle with data 0xDEADBEEF -> wb_valid_o exactly 3 cycles after accept, wb_reg_wdata_o=0xDEADBEEF.
REQ-032 LB addr 0x103, rdata 0x80112233 -> wb_reg_wdata_o=0xFFFFFF80; LBU on the same access -> 0x00000080.
REQ-033 SH addr 0x202, wdata 0x0000ABCD, gnt delayed 4 cycles -> bus_req_o held 5 cycles, bus_be_o=4'b1100, bus_wdata_o[31:16]=0xABCD, ex_ready_o=0 throughout.
REQ-034 Back-to-back ALU ops (no mem enables) on 3 cycles -> wb_valid_o high 3 consecutive cycles, each 1 cycle later than its accept.
REQ-035 rst pulse during WAIT, then rvalid -> no wb_valid_o, state IDLE, bus_req_o=0.
REQ-036 MISALIGN_TRAP_EN defined, LW addr 0x101 -> bus_req_o stays 0, misalign_o=1 and wb_reg_wena_o=0 the next cycle.

Source files
------------

// File: rtl/mem_lsu.sv
// Load/store unit: accepts one EX-stage instruction at a time, runs a req/gnt/rvalid bus access
// for loads and stores, and registers the write-back. Optional build macro: MISALIGN_TRAP_EN.
module mem_lsu #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_valid_i,
   output logic              ex_ready_o,
   input  logic [31:0]       inst_i,
   input  logic              mem_rena_i,
   input  logic              mem_wena_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic [XLEN-1:0]   mem_wdata_i,
   input  logic              reg_wena_i,
   input  logic [4:0]        reg_waddr_i,
   input  logic [XLEN-1:0]   reg_wdata_i,
   output logic              bus_req_o,
   output logic              bus_we_o,
   output logic [ADDR_W-1:0] bus_addr_o,
   output logic [XLEN-1:0]   bus_wdata_o,
   output logic [XLEN/8-1:0] bus_be_o,
   input  logic              bus_gnt_i,
   input  logic              bus_rvalid_i,
   input  logic [XLEN-1:0]   bus_rdata_i,
   output logic              wb_valid_o,
   output logic [31:0]       wb_inst_o,
   output logic              wb_reg_wena_o,
   output logic [4:0]        wb_reg_waddr_o,
   output logic [XLEN-1:0]   wb_reg_wdata_o,
`ifdef MISALIGN_TRAP_EN
   output logic              misalign_o,
`endif
   output logic              busy_o
);

   localparam int unsigned NB     = XLEN / 8;
   localparam int unsigned OFFW   = $clog2(NB);
   localparam logic [1:0]  FullSz = 2'(OFFW);

   typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

   state_e state_q, state_d;

   logic [31:0]       inst_q;
   logic              store_q;
   logic [ADDR_W-1:0] addr_q;
   logic [1:0]        size_q;
   logic              uns_q;
   logic [XLEN-1:0]   wdata_q;
   logic              reg_wena_q;
   logic [4:0]        reg_waddr_q;
   logic [XLEN-1:0]   reg_wdata_q;

   logic              wb_valid_q, wb_valid_d;
   logic [31:0]       wb_inst_q, wb_inst_d;
   logic              wb_reg_wena_q, wb_reg_wena_d;
   logic [4:0]        wb_reg_waddr_q, wb_reg_waddr_d;
   logic [XLEN-1:0]   wb_reg_wdata_q, wb_reg_wdata_d;

   logic              accept, latch_en, acc_uns;
   logic [1:0]        acc_sz;
   logic [2:0]        lo_mask;
   logic [ADDR_W-1:0] addr_fix;
   logic [OFFW-1:0]   off;
   logic [7:0]        be_base, be_sh;
   logic [XLEN-1:0]   rd_sh, ld_data;

   assign ex_ready_o = (state_q == StIdle) && !rst;
   assign busy_o     = (state_q != StIdle) && !rst;
   assign accept     = ex_valid_i && ex_ready_o;

   // Access size (log2 bytes) and signedness from funct3; unlisted codes mean full width.
   always_comb begin
      acc_sz  = FullSz;
      acc_uns = 1'b0;
      if (mem_wena_i) begin
         case (inst_i[14:12])
            3'b000:  acc_sz = 2'd0;
            3'b001:  acc_sz = 2'd1;
            3'b010:  acc_sz = 2'd2;
            default: acc_sz = FullSz;
         endcase
      end else begin
         case (inst_i[14:12])
            3'b000:  acc_sz = 2'd0;
            3'b001:  acc_sz = 2'd1;
            3'b010:  acc_sz = 2'd2;
            3'b100: begin acc_sz = 2'd0; acc_uns = 1'b1; end
            3'b101: begin acc_sz = 2'd1; acc_uns = 1'b1; end
            3'b110: if (XLEN == 64) begin acc_sz = 2'd2; acc_uns = 1'b1; end
            default: acc_sz = FullSz;
         endcase
      end
      case (acc_sz)
         2'd0:    lo_mask = 3'b000;
         2'd1:    lo_mask = 3'b001;
         2'd2:    lo_mask = 3'b011;
         default: lo_mask = 3'b111;
      endcase
      addr_fix = mem_addr_i & ~{{(ADDR_W-3){1'b0}}, lo_mask};
   end

`ifdef MISALIGN_TRAP_EN
   logic misal, misal_q, misal_d;
   assign misal      = |(mem_addr_i[2:0] & lo_mask);
   assign misalign_o = misal_q;
`endif

   // Bus side is driven purely from the latched request, so it holds steady while waiting on gnt.
   assign off        = addr_q[OFFW-1:0];
   assign bus_req_o  = (state_q == StReq);
   assign bus_we_o   = store_q;
   assign bus_addr_o = {addr_q[ADDR_W-1:OFFW], {OFFW{1'b0}}};
   assign be_sh      = be_base << off;
   assign bus_be_o   = be_sh[NB-1:0];
   assign rd_sh      = bus_rdata_i >> {off, 3'b000};

   always_comb begin
      case (size_q)
         2'd0:    begin be_base = 8'h01; bus_wdata_o = {NB{wdata_q[7:0]}}; end
         2'd1:    begin be_base = 8'h03; bus_wdata_o = {(NB/2){wdata_q[15:0]}}; end
         2'd2:    begin be_base = 8'h0f; bus_wdata_o = {(NB/4){wdata_q[31:0]}}; end
         default: begin be_base = 8'hff; bus_wdata_o = wdata_q; end
      endcase
   end

   always_comb begin
      int nb;
      logic ext;
      nb  = 8 << size_q;
      ext = !uns_q && rd_sh[nb-1];
      for (int i = 0; i < XLEN; i++) begin
         ld_data[i] = (i < nb) ? rd_sh[i] : ext;
      end
   end

   always_comb begin
      state_d        = state_q;
      latch_en       = 1'b0;
      wb_valid_d     = 1'b0;
      wb_inst_d      = wb_inst_q;
      wb_reg_wena_d  = wb_reg_wena_q;
      wb_reg_waddr_d = wb_reg_waddr_q;
      wb_reg_wdata_d = wb_reg_wdata_q;
`ifdef MISALIGN_TRAP_EN
      misal_d        = 1'b0;
`endif
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (mem_rena_i || mem_wena_i) begin
`ifdef MISALIGN_TRAP_EN
                  if (misal) begin
                     wb_valid_d     = 1'b1;
                     wb_inst_d      = inst_i;
                     wb_reg_wena_d  = 1'b0;
                     wb_reg_waddr_d = reg_waddr_i;
                     wb_reg_wdata_d = '0;
                     misal_d        = 1'b1;
                  end else begin
                     latch_en = 1'b1;
                     state_d  = StReq;
                  end
`else
                  latch_en = 1'b1;
                  state_d  = StReq;
`endif
               end else begin
                  wb_valid_d     = 1'b1;
                  wb_inst_d      = inst_i;
                  wb_reg_wena_d  = reg_wena_i;
                  wb_reg_waddr_d = reg_waddr_i;
                  wb_reg_wdata_d = reg_wdata_i;
               end
            end
         end
         StReq: begin
            if (bus_gnt_i) state_d = StWait;
         end
         StWait: begin
            if (bus_rvalid_i) begin
               wb_valid_d     = 1'b1;
               wb_inst_d      = inst_q;
               wb_reg_waddr_d = reg_waddr_q;
               wb_reg_wena_d  = store_q ? reg_wena_q : 1'b1;
               wb_reg_wdata_d = store_q ? reg_wdata_q : ld_data;
               state_d        = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= StIdle;
         wb_valid_q     <= 1'b0;
         wb_inst_q      <= '0;
         wb_reg_wena_q  <= 1'b0;
         wb_reg_waddr_q <= '0;
         wb_reg_wdata_q <= '0;
`ifdef MISALIGN_TRAP_EN
         misal_q        <= 1'b0;
`endif
      end else begin
         state_q        <= state_d;
         wb_valid_q     <= wb_valid_d;
         wb_inst_q      <= wb_inst_d;
         wb_reg_wena_q  <= wb_reg_wena_d;
         wb_reg_waddr_q <= wb_reg_waddr_d;
         wb_reg_wdata_q <= wb_reg_wdata_d;
`ifdef MISALIGN_TRAP_EN
         misal_q        <= misal_d;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         inst_q      <= '0;
         store_q     <= 1'b0;
         addr_q      <= '0;
         size_q      <= '0;
         uns_q       <= 1'b0;
         wdata_q     <= '0;
         reg_wena_q  <= 1'b0;
         reg_waddr_q <= '0;
         reg_wdata_q <= '0;
      end else if (latch_en) begin
         inst_q      <= inst_i;
         store_q     <= mem_wena_i;
         addr_q      <= addr_fix;
         size_q      <= acc_sz;
         uns_q       <= acc_uns;
         wdata_q     <= mem_wdata_i;
         reg_wena_q  <= reg_wena_i;
         reg_waddr_q <= reg_waddr_i;
         reg_wdata_q <= reg_wdata_i;
      end
   end

   assign wb_valid_o     = wb_valid_q;
   assign wb_inst_o      = wb_inst_q;
   assign wb_reg_wena_o  = wb_reg_wena_q;
   assign wb_reg_waddr_o = wb_reg_waddr_q;
   assign wb_reg_wdata_o = wb_reg_wdata_q;

endmodule
